// File: rtl/mem_pkg.sv
// Shared definitions for the MIG user-port clients.
//   - MIG command encodings driven on cmd_instr.
//   - capture_dma FSM state encoding.
//   - cap64: clamps a word count into the 7-bit burst-length domain (1..64).
package mem_pkg;

    localparam logic [2:0] MEM_WRITE    = 3'b000;
    localparam logic [2:0] MEM_READ     = 3'b001;
    localparam logic [2:0] MEM_WRITE_AP = 3'b010;
    localparam logic [2:0] MEM_READ_AP  = 3'b011;
    localparam logic [2:0] MEM_REFRESH  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        CMD  = 2'd2
    } dma_state_t;

    // Bursts never exceed 64 words, so any larger count saturates at 64.
    function automatic logic [6:0] cap64(input logic [24:0] v);
        return (v > 25'd64) ? 7'd64 : v[6:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clock, reset    : clock and asynchronous active-low reset
//   clear           : empties the FIFO; a push in the same cycle is kept as
//                     the only entry
//   push, din       : write a word (ignored when full and not clearing)
//   pop, dout       : dout always shows the head word; pop advances it
//   count           : number of stored words (0..2**DEPTH_LOG2)
//   full, empty     : status flags derived from count
module sync_fifo #(
    parameter int DEPTH_LOG2 = 7,
    parameter int WIDTH      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int PW    = DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    wr_addr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & (clear | ~full);
    assign do_pop  = pop & ~empty & ~clear;
    assign dout    = mem[rd_ptr];
    // A push that coincides with clear lands at slot 0 of the emptied FIFO.
    assign wr_addr = clear ? '0 : wr_ptr;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_addr] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= PW'(do_push);
            count  <= CW'(do_push);
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/capture_dma.sv
// Capture DMA: buffers 32-bit capture samples locally and writes them into a
// DRAM ring buffer through a MIG user port (write-FIFO fill, then one write
// command per burst).
//   clock, reset          : single clock, asynchronous active-low reset
//   enable, flush         : capture enable (rising edge restarts ring),
//                           flush allows partial bursts
//   base_addr, ring_words : ring placement (byte address) and length (words)
//   s_data/s_valid/s_ready: sample stream input
//   wr_ptr                : committed word offset into the ring
//   overflow, mem_error   : sticky error flags
//   busy                  : FSM active or samples pending
//   cmd_*                 : MIG command port
//   wr_*                  : MIG write data port
//   debug                 : {state, cmd_empty, wr_empty, wr_count}
//
// state | meaning
// IDLE  | waiting for enough buffered words to start a burst
// FILL  | pushing n words into the MIG write FIFO
// CMD   | issuing the MEM_WRITE command for the burst
module capture_dma
    import mem_pkg::*;
#(
    parameter int BURST_WORDS     = 32,
    parameter int FIFO_DEPTH_LOG2 = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        flush,
    input  logic [29:0] base_addr,
    input  logic [23:0] ring_words,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [23:0] wr_ptr,
    output logic        overflow,
    output logic        mem_error,
    output logic        busy,
    output logic        cmd_clk,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    input  logic        cmd_empty,
    input  logic        cmd_full,
    output logic        wr_clk,
    output logic        wr_en,
    output logic [3:0]  wr_mask,
    output logic [31:0] wr_data,
    input  logic        wr_full,
    input  logic        wr_empty,
    input  logic [6:0]  wr_count,
    input  logic        wr_underrun,
    input  logic        wr_error,
    output logic [10:0] debug
);

    localparam int CW = FIFO_DEPTH_LOG2 + 1;

    dma_state_t    state;
    dma_state_t    state_next;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_dout;
    logic          push;

    logic          live;
    logic          enable_q;
    logic          rise;
    logic          clear_pending;
    logic          do_clear;

    logic [23:0]   offset;
    logic [23:0]   remaining;
    logic [23:0]   offset_sum;
    logic [23:0]   offset_wrap;
    logic [24:0]   count_x;
    logic [24:0]   remaining_x;
    logic [24:0]   burst_x;
    logic [6:0]    n_next;
    logic [6:0]    n_q;
    logic [6:0]    fill_cnt;
    logic          can_start;

    // live keeps s_ready low while reset is asserted, independent of enable.
    assign rise     = enable & ~enable_q;
    assign do_clear = (rise | clear_pending) & (state == IDLE);
    assign s_ready  = live & enable & ~fifo_full;
    assign push     = s_valid & s_ready;

    sync_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (32)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (do_clear),
        .push  (push),
        .din   (s_data),
        .pop   (wr_en),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Burst sizing: n = min(BURST_WORDS, fifo_count, words left before ring end).
    assign remaining   = ring_words - offset;
    assign count_x     = 25'(fifo_count);
    assign remaining_x = {1'b0, remaining};
    assign burst_x     = 25'(BURST_WORDS);

    always_comb begin
        n_next = cap64(burst_x);
        if (cap64(count_x) < n_next) begin
            n_next = cap64(count_x);
        end
        if (cap64(remaining_x) < n_next) begin
            n_next = cap64(remaining_x);
        end
    end

    // A short tail before the ring end starts as soon as it is fully buffered,
    // so a burst never straddles the wrap point.
    assign can_start = (fifo_count != '0) && (remaining != '0) &&
                       ((count_x >= burst_x) || flush || (remaining_x <= count_x));

    assign offset_sum  = offset + 24'(n_q);
    assign offset_wrap = (offset_sum >= ring_words) ? 24'd0 : offset_sum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!do_clear && can_start) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (wr_en && (fill_cnt == n_q - 7'd1)) begin
                    state_next = CMD;
                end
            end
            CMD: begin
                if (!cmd_full) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_en         = 1'b0;
        wr_data       = 32'd0;
        cmd_en        = 1'b0;
        cmd_bl        = 6'd0;
        cmd_byte_addr = 30'd0;
        case (state)
            FILL: begin
                if (!wr_full) begin
                    wr_en   = 1'b1;
                    wr_data = fifo_dout;
                end
            end
            CMD: begin
                cmd_en        = 1'b1;
                cmd_bl        = 6'(n_q - 7'd1);
                cmd_byte_addr = (base_addr & 30'h3FFF_FFFC) + {4'b0000, offset, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            live          <= 1'b0;
            enable_q      <= 1'b0;
            clear_pending <= 1'b0;
            offset        <= 24'd0;
            overflow      <= 1'b0;
            mem_error     <= 1'b0;
            n_q           <= 7'd0;
            fill_cnt      <= 7'd0;
        end else begin
            live     <= 1'b1;
            enable_q <= enable;

            if (do_clear) begin
                clear_pending <= 1'b0;
            end else if (rise) begin
                clear_pending <= 1'b1;
            end

            if (do_clear) begin
                offset    <= 24'd0;
                overflow  <= 1'b0;
                mem_error <= 1'b0;
            end else begin
                if (s_valid && enable && live && fifo_full) begin
                    overflow <= 1'b1;
                end
                if (wr_underrun || wr_error) begin
                    mem_error <= 1'b1;
                end
                if ((state == CMD) && !cmd_full) begin
                    offset <= offset_wrap;
                end
            end

            if ((state == IDLE) && (state_next == FILL)) begin
                n_q      <= n_next;
                fill_cnt <= 7'd0;
            end else if (wr_en) begin
                fill_cnt <= fill_cnt + 7'd1;
            end
        end
    end

    assign wr_ptr    = offset;
    assign busy      = (state != IDLE) | ~fifo_empty;
    assign cmd_instr = MEM_WRITE;
    assign wr_mask   = 4'b0000;
    assign cmd_clk   = clock;
    assign wr_clk    = clock;
    assign debug     = {state, cmd_empty, wr_empty, wr_count};

endmodule

// File: tb/tb_capture_dma.sv
module tb_capture_dma;

    localparam int BW = 4;
    localparam int DL = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [29:0] base_addr = 30'h100;
    logic [23:0] ring_words = 24'd16;
    logic [31:0] s_data = 32'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] wr_ptr;
    logic        overflow;
    logic        mem_error;
    logic        busy;
    logic        cmd_clk;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_empty = 1'b1;
    logic        cmd_full = 1'b0;
    logic        wr_clk;
    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic        wr_full = 1'b0;
    logic        wr_empty = 1'b1;
    logic [6:0]  wr_count = 7'd0;
    logic        wr_underrun = 1'b0;
    logic        wr_error = 1'b0;
    logic [10:0] debug;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] wdata_q[$];
    logic [29:0] caddr_q[$];
    logic [5:0]  cbl_q[$];
    int          cmd_pulses = 0;
    logic        cmd_en_prev = 1'b0;

    capture_dma #(
        .BURST_WORDS     (BW),
        .FIFO_DEPTH_LOG2 (DL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .flush         (flush),
        .base_addr     (base_addr),
        .ring_words    (ring_words),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .wr_ptr        (wr_ptr),
        .overflow      (overflow),
        .mem_error     (mem_error),
        .busy          (busy),
        .cmd_clk       (cmd_clk),
        .cmd_en        (cmd_en),
        .cmd_instr     (cmd_instr),
        .cmd_bl        (cmd_bl),
        .cmd_byte_addr (cmd_byte_addr),
        .cmd_empty     (cmd_empty),
        .cmd_full      (cmd_full),
        .wr_clk        (wr_clk),
        .wr_en         (wr_en),
        .wr_mask       (wr_mask),
        .wr_data       (wr_data),
        .wr_full       (wr_full),
        .wr_empty      (wr_empty),
        .wr_count      (wr_count),
        .wr_underrun   (wr_underrun),
        .wr_error      (wr_error),
        .debug         (debug)
    );

    always #5 clock = ~clock;

    // Passive observer of the MIG ports, sampled mid-cycle.
    always @(negedge clock) begin
        if (wr_en) begin
            wdata_q.push_back(wr_data);
        end
        if (cmd_en && !cmd_full) begin
            caddr_q.push_back(cmd_byte_addr);
            cbl_q.push_back(cmd_bl);
        end
        if (cmd_en && !cmd_en_prev) begin
            cmd_pulses++;
        end
        cmd_en_prev = cmd_en;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish before 300us");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        wdata_q.delete();
        caddr_q.delete();
        cbl_q.delete();
        cmd_pulses = 0;
    endtask

    task automatic push_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            int   k;
            logic ok;
            s_data  = 32'(first + i);
            s_valid = 1'b1;
            k  = 0;
            ok = 1'b0;
            while (!ok && k < 100) begin
                @(negedge clock);
                ok = s_ready;
                @(posedge clock);
                #1;
                k++;
            end
            check("push_accept", 64'(ok), 64'd1);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 400) begin
            @(negedge clock);
            k++;
        end
        check(tag, 64'(busy), 64'd0);
        step();
    endtask

    task automatic restart(input logic [23:0] ring);
        enable = 1'b0;
        #1;
        check("enable_low_ready", 64'(s_ready), 64'd0);
        ring_words = ring;
        step();
        enable = 1'b1;
        step();
    endtask

    task automatic check_data(input string tag, input int first, input int n);
        check({tag, "_count"}, 64'(wdata_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            check({tag, "_word"}, (i < wdata_q.size()) ? 64'(wdata_q[i]) : 64'hDEAD_DEAD,
                  64'(first + i));
        end
    endtask

    task automatic check_cmd(input string tag, input int idx, input logic [29:0] addr,
                             input logic [5:0] bl);
        check({tag, "_addr"}, (idx < caddr_q.size()) ? 64'(caddr_q[idx]) : 64'hDEAD_DEAD,
              64'(addr));
        check({tag, "_bl"}, (idx < cbl_q.size()) ? 64'(cbl_q[idx]) : 64'hDEAD_DEAD, 64'(bl));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_mem_error"}, 64'(mem_error), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_wr_ptr"}, 64'(wr_ptr), 64'd0);
        check({tag, "_cmd_en"}, 64'(cmd_en), 64'd0);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_cmd_bl"}, 64'(cmd_bl), 64'd0);
        check({tag, "_cmd_addr"}, 64'(cmd_byte_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        check({tag, "_wr_mask"}, 64'(wr_mask), 64'd0);
        check({tag, "_cmd_instr"}, 64'(cmd_instr), 64'd0);
    endtask

    initial begin
        // Reset with enable and s_valid already high: s_ready must stay low.
        #2;
        reset   = 1'b0;
        enable  = 1'b1;
        s_valid = 1'b1;
        #2;
        check_all_zero("reset");
        @(negedge clock);
        s_valid = 1'b0;
        enable  = 1'b0;
        reset   = 1'b1;
        step();
        step();

        // 1. Stream: two full bursts at 0x100 and 0x110.
        base_addr = 30'h100;
        restart(24'd16);
        clear_logs();
        push_words(1, 8);
        wait_idle("t1_idle");
        check("t1_ncmd", 64'(caddr_q.size()), 64'd2);
        check_cmd("t1_c0", 0, 30'h100, 6'd3);
        check_cmd("t1_c1", 1, 30'h110, 6'd3);
        check_data("t1_data", 1, 8);
        check("t1_wr_ptr", 64'(wr_ptr), 64'd8);
        check("t1_pulses", 64'(cmd_pulses), 64'd2);

        // 2. Wrap: ring of 6 words, bursts 4 then 2, twice.
        restart(24'd6);
        check("t2_ptr_cleared", 64'(wr_ptr), 64'd0);
        clear_logs();
        push_words(101, 12);
        wait_idle("t2_idle");
        check("t2_ncmd", 64'(caddr_q.size()), 64'd4);
        check_cmd("t2_c0", 0, 30'h100, 6'd3);
        check_cmd("t2_c1", 1, 30'h110, 6'd1);
        check_cmd("t2_c2", 2, 30'h100, 6'd3);
        check_cmd("t2_c3", 3, 30'h110, 6'd1);
        check_data("t2_data", 101, 12);
        check("t2_wr_ptr", 64'(wr_ptr), 64'd0);

        // 3. Backpressure: wr_full mid-FILL for 5 cycles, cmd_full 3 cycles in CMD.
        restart(24'd16);
        clear_logs();
        push_words(201, 4);
        step();
        check("t3_fill_wr_en", 64'(wr_en), 64'd1);
        check("t3_fill_head", 64'(wr_data), 64'd201);
        step();
        wr_full = 1'b1;
        #1;
        check("t3_stall_wr_en", 64'(wr_en), 64'd0);
        check("t3_words_before", 64'(wdata_q.size()), 64'd1);
        repeat (5) step();
        check("t3_words_stalled", 64'(wdata_q.size()), 64'd1);
        check("t3_busy", 64'(busy), 64'd1);
        wr_full  = 1'b0;
        cmd_full = 1'b1;
        begin
            int k;
            k = 0;
            while (!cmd_en && k < 50) begin
                @(negedge clock);
                k++;
            end
            check("t3_cmd_seen", 64'(cmd_en), 64'd1);
        end
        repeat (3) step();
        check("t3_cmd_held", 64'(cmd_en), 64'd1);
        check("t3_cmd_bl", 64'(cmd_bl), 64'd3);
        check("t3_cmd_addr", 64'(cmd_byte_addr), 64'h100);
        check("t3_cmd_instr", 64'(cmd_instr), 64'd0);
        cmd_full = 1'b0;
        wait_idle("t3_idle");
        check("t3_ncmd", 64'(caddr_q.size()), 64'd1);
        check("t3_pulses", 64'(cmd_pulses), 64'd1);
        check_data("t3_data", 201, 4);
        check("t3_wr_ptr", 64'(wr_ptr), 64'd4);

        // 4. Overflow: nothing drains, 12 samples into an 8-deep FIFO.
        restart(24'd16);
        check("t4_ptr_cleared", 64'(wr_ptr), 64'd0);
        clear_logs();
        wr_full  = 1'b1;
        cmd_full = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_data  = 32'(301 + i);
            s_valid = 1'b1;
            @(negedge clock);
            if (i == 7) begin
                check("t4_ready_at_7", 64'(s_ready), 64'd1);
            end
            if (i == 8) begin
                check("t4_ready_at_8", 64'(s_ready), 64'd0);
                check("t4_no_ovf_yet", 64'(overflow), 64'd0);
            end
            step();
        end
        s_valid = 1'b0;
        check("t4_ready_low", 64'(s_ready), 64'd0);
        check("t4_overflow", 64'(overflow), 64'd1);
        wr_full = 1'b0;
        repeat (10) step();
        check("t4_cmd_stuck", 64'(cmd_en), 64'd1);
        cmd_full = 1'b0;
        wait_idle("t4_idle");
        check_data("t4_data", 301, 8);
        check("t4_ncmd", 64'(caddr_q.size()), 64'd2);
        check_cmd("t4_c1", 1, 30'h110, 6'd3);
        check("t4_ovf_sticky", 64'(overflow), 64'd1);
        restart(24'd16);
        check("t4_ovf_cleared", 64'(overflow), 64'd0);
        check("t4_ptr_restart", 64'(wr_ptr), 64'd0);

        // mem_error: sticky until enable rising edge.
        wr_error = 1'b1;
        step();
        wr_error = 1'b0;
        check("me_set", 64'(mem_error), 64'd1);
        step();
        wr_underrun = 1'b1;
        step();
        wr_underrun = 1'b0;
        step();
        check("me_sticky", 64'(mem_error), 64'd1);
        restart(24'd16);
        check("me_cleared", 64'(mem_error), 64'd0);

        // 5. Flush: 3 words sit until flush allows a partial burst.
        clear_logs();
        push_words(401, 3);
        repeat (5) step();
        check("t5_pending_busy", 64'(busy), 64'd1);
        check("t5_no_cmd", 64'(cmd_pulses), 64'd0);
        flush = 1'b1;
        wait_idle("t5_idle");
        flush = 1'b0;
        check("t5_ncmd", 64'(caddr_q.size()), 64'd1);
        check_cmd("t5_c0", 0, 30'h100, 6'd2);
        check_data("t5_data", 401, 3);
        check("t5_wr_ptr", 64'(wr_ptr), 64'd3);

        // 6. Reset mid-FILL, then restart from base_addr.
        clear_logs();
        wr_full = 1'b1;
        push_words(501, 4);
        step();
        check("t6_stalled", 64'(wr_en), 64'd0);
        wr_full = 1'b0;
        #1;
        check("t6_fill_wr_en", 64'(wr_en), 64'd1);
        check("t6_fill_head", 64'(wr_data), 64'd501);
        reset = 1'b0;
        #1;
        check_all_zero("t6_reset");
        @(negedge clock);
        reset = 1'b1;
        step();
        clear_logs();
        push_words(601, 4);
        wait_idle("t6_idle");
        check("t6_ncmd", 64'(caddr_q.size()), 64'd1);
        check_cmd("t6_c0", 0, 30'h100, 6'd3);
        check_data("t6_data", 601, 4);
        check("t6_wr_ptr", 64'(wr_ptr), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
